// File: rtl/warmup_pkg.sv
// Shared encodings and constants for the warmup counter monitor and its reference model.
// Optional halt-on-first-mismatch behaviour is selected with WARMUP_MON_HALT_EN in warmup_monitor.
package warmup_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] A_SAT   = 4'd2;

  localparam int A_BIT = 0;
  localparam int B_BIT = 1;
  localparam int C_BIT = 2;

endpackage

// File: rtl/warmup_ref_model.sv
// Golden copy of the upstream 4-bit warmup counter: free-running ref_cnt plus the
// expected a/b/c buses, with b modelled as a one-cycle delayed a.
module warmup_ref_model
  import warmup_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  output logic [3:0] ref_cnt,
  output logic [3:0] a_exp,
  output logic [3:0] b_exp,
  output logic [3:0] c_exp
);

  logic [3:0] ref_cnt_q, ref_cnt_d;
  logic [3:0] b_exp_q, b_exp_d;

  always_comb begin
    ref_cnt_d = (ref_cnt_q == CNT_MAX) ? 4'd0 : ref_cnt_q + 4'd1;

    if (ref_cnt_q == 4'd0)      a_exp = 4'd0;
    else if (ref_cnt_q == 4'd1) a_exp = 4'd1;
    else                        a_exp = A_SAT;

    c_exp   = (ref_cnt_q <= 4'd2) ? ref_cnt_q : 4'd0;
    b_exp_d = a_exp;
  end

  // Counts on every non-reset cycle so it stays aligned with the upstream stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ref_cnt_q <= 4'd0;
      b_exp_q   <= 4'd0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      b_exp_q   <= b_exp_d;
    end
  end

  assign ref_cnt = ref_cnt_q;
  assign b_exp   = b_exp_q;

endmodule

// File: rtl/warmup_monitor.sv
// Checks the upstream warmup counter buses against warmup_ref_model over a bounded window.
// Define WARMUP_MON_HALT_EN to end the run on the first mismatching compare.
module warmup_monitor
  import warmup_pkg::*;
#(
  parameter int CHECK_CYCLES = 32,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  input  logic [3:0]       c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_mask,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [3:0] ref_cnt, a_exp, b_exp, c_exp;
  logic [2:0] m;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [2:0]       ffm_q, ffm_d;

  warmup_ref_model u_ref (
    .clk     (clk),
    .resetn  (resetn),
    .ref_cnt (ref_cnt),
    .a_exp   (a_exp),
    .b_exp   (b_exp),
    .c_exp   (c_exp)
  );

  always_comb begin
    m        = 3'b000;
    m[A_BIT] = (a_in != a_exp);
    m[B_BIT] = (b_in != b_exp);
    m[C_BIT] = (c_in != c_exp);

    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ffi_d   = ffi_q;
    ffm_d   = ffm_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = CHECK;
          err_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          ffi_d   = '0;
          ffm_d   = 3'b000;
        end
      end
      CHECK: begin
        // Dropping enable abandons the run without comparing this cycle.
        if (!enable) begin
          state_d = IDLE;
        end else begin
          if (|m) begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            if (!err_q) begin
              ffi_d = idx_q;
              ffm_d = m;
              err_d = 1'b1;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
`ifdef WARMUP_MON_HALT_EN
          if (|m) state_d = DONE;
`else
`endif
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && !err_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ffi_q   <= '0;
      ffm_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ffi_q   <= ffi_d;
      ffm_q   <= ffm_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err             = err_q;
  assign mismatch_cnt    = cnt_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_mask = ffm_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_warmup_monitor.sv
// Directed bench for warmup_monitor: a bench-side upstream stage with fault injection,
// a behavioural checker model compared every cycle, and hand-computed end-of-run pins.
module tb_warmup_monitor;

  localparam int CC    = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             enable = 1'b0;
  logic [3:0]       a_in = '0, b_in = '0, c_in = '0;
  logic             busy, done, pass, err;
  logic [CNT_W-1:0] mismatch_cnt, first_fail_idx;
  logic [2:0]       first_fail_mask;
  logic [1:0]       dbg_state;

  warmup_monitor #(.CHECK_CYCLES(CC), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .a_in            (a_in),
    .b_in            (b_in),
    .c_in            (c_in),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err             (err),
    .mismatch_cnt    (mismatch_cnt),
    .first_fail_idx  (first_fail_idx),
    .first_fail_mask (first_fail_mask),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Upstream stage state and fault controls
  int         u_cnt = 0;
  logic [3:0] good_b = '0;
  bit         fault_b = 0, fault_c = 0, glitch_a = 0;

  // Checker model: phase 0 idle, 1 running, 2 finished
  int         m_phase = 0, m_idx = 0, m_cnt = 0, m_fi = 0;
  bit         m_err = 0;
  logic [2:0] m_fm = '0;

  function automatic logic [3:0] fa(input int r);
    if (r == 0) return 4'd0;
    if (r == 1) return 4'd1;
    return 4'd2;
  endfunction

  function automatic logic [3:0] fc(input int r);
    return (r <= 2) ? 4'(r) : 4'd0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
  endtask

  task automatic model_update();
    logic [2:0] mm;
    if (!resetn) begin
      u_cnt = 0; good_b = '0;
      m_phase = 0; m_idx = 0; m_cnt = 0; m_fi = 0; m_err = 0; m_fm = '0;
    end else begin
      mm = {c_in != fc(u_cnt), b_in != good_b, a_in != fa(u_cnt)};
      if (m_phase == 0) begin
        if (enable) begin
          m_phase = 1; m_idx = 0; m_cnt = 0; m_fi = 0; m_err = 0; m_fm = '0;
        end
      end else if (m_phase == 1) begin
        if (!enable) m_phase = 0;
        else begin
          if (mm != 0) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!m_err) begin m_fi = m_idx; m_fm = mm; m_err = 1; end
`ifdef WARMUP_MON_HALT_EN
            m_phase = 2;
`endif
          end
          if (m_idx == CC - 1) m_phase = 2;
          m_idx++;
        end
      end else if (!enable) m_phase = 0;
      good_b = fa(u_cnt);
      u_cnt = (u_cnt + 1) % 16;
    end
  endtask

  task automatic compare();
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    check("pass", pass, (m_phase == 2) && !m_err);
    check("err", err, m_err);
    check("mismatch_cnt", mismatch_cnt, m_cnt);
    check("first_fail_idx", first_fail_idx, m_fi);
    check("first_fail_mask", first_fail_mask, m_fm);
  endtask

  // One clock: drive upstream buses, let DUT and model sample, compare on the falling edge.
  task automatic tick();
    a_in = fa(u_cnt) ^ (glitch_a ? 4'd1 : 4'd0);
    b_in = fault_b ? a_in : good_b;
    c_in = fault_c ? 4'd0 : fc(u_cnt);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  // Reset, one idle cycle, then enable held high from the 2nd cycle after release.
  task automatic start_run();
    resetn = 1'b0; enable = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    enable = 1'b1;
  endtask

  task automatic run_to_done(input string name);
    for (int i = 0; i < CC + 8 && !done; i++) tick();
    check({name, "_done_timeout"}, done, 1);
  endtask

  task automatic run_to_idx(input int idx);
    for (int i = 0; i < CC + 8 && !(m_phase == 1 && m_idx == idx); i++) tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_cnt", mismatch_cnt, 0);

    // Clean upstream: 32 compares at ref_cnt 2..15,0..15,0,1
    start_run();
    run_to_done("clean");
    check("clean_pass", pass, 1);
    check("clean_cnt", mismatch_cnt, 0);
    check("clean_mask", first_fail_mask, 0);

    // b without its delay: mismatches at ref_cnt 0,1,2 after wrap, and at 2 on idx 0
    fault_b = 1;
    start_run();
    run_to_done("bfault");
    check("bfault_pass", pass, 0);
    check("bfault_mask", first_fail_mask, 3'b010);
    check("bfault_idx", first_fail_idx, 0);
`ifdef WARMUP_MON_HALT_EN
    check("bfault_cnt", mismatch_cnt, 1);
`else
    check("bfault_cnt", mismatch_cnt, 6);
`endif
    fault_b = 0;

    // c stuck at 0: mismatches at ref_cnt 1 and 2 -> idx 0,15,16,31
    fault_c = 1;
    start_run();
    run_to_done("cfault");
    check("cfault_mask", first_fail_mask, 3'b100);
    check("cfault_err", err, 1);
`ifdef WARMUP_MON_HALT_EN
    check("cfault_cnt", mismatch_cnt, 1);
`else
    check("cfault_cnt", mismatch_cnt, 4);
`endif
    fault_c = 0;

    // Single a glitch on the last compare
    start_run();
    run_to_idx(CC - 1);
    glitch_a = 1;
    tick();
    glitch_a = 0;
    check("last_done", done, 1);
    check("last_cnt", mismatch_cnt, 1);
    check("last_idx", first_fail_idx, 31);
    check("last_mask", first_fail_mask, 3'b001);

    // enable dropped at idx 10 for 3 cycles, then a full restart
    start_run();
    run_to_idx(10);
    enable = 1'b0;
    tick();
    check("drop_busy", busy, 0);
    check("drop_done", done, 0);
    tick(); tick();
    enable = 1'b1;
    tick();
    check("restart_busy", busy, 1);
    run_to_done("restart");
    check("restart_pass", pass, 1);

    // Reset pulse mid-run with an error already latched
    fault_c = 1;
    start_run();
    repeat (6) tick();
    fault_c = 0;
    resetn = 1'b0;
    tick();
    check("midrst_err", err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", mismatch_cnt, 0);
    resetn = 1'b1;
    run_to_done("midrst");
    check("midrst_pass", pass, 1);
    check("midrst_final_cnt", mismatch_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
